// File: rtl/mask_rand_gen.sv
// Fresh-randomness source for the masked SKINNY core: nine 16-bit Galois LFSR
// lanes, seeded, warmed up, then stepped once per accepted 144-bit word.
module mask_rand_gen #(
   parameter int STEPS           = 16,
   parameter int WARMUP          = 4,
   parameter int RESEED_INTERVAL = 1024
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         seed_valid,
   input  logic [143:0] seed,
   output logic [143:0] r,
   output logic         r_valid,
   input  logic         r_ready,
   output logic         reseed_req,
   output logic         seeded
);

   localparam int CW = (RESEED_INTERVAL > 0) ? $clog2(RESEED_INTERVAL + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(RESEED_INTERVAL);
   localparam logic [3:0]    WARM_INIT = 4'(WARMUP);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WARMUP,
      S_RUN
   } state_t;

   state_t          fsm_q, fsm_d;
   logic [143:0]    state_q, state_d;
   logic [3:0]      warm_q, warm_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            req_q, req_d;
   logic            seeded_q, seeded_d;
   logic [143:0]    upd;
   logic [143:0]    seed_prot;

   // Per-lane update (STEPS unrolled steps) and zero-protected seed load.
   generate
      for (genvar gi = 0; gi < 9; gi++) begin : g_lane
         logic [15:0] lane_upd;
         always_comb begin
            lane_upd = state_q[16*gi +: 16];
            for (int k = 0; k < STEPS; k++) begin
               if (lane_upd[0]) lane_upd = {1'b0, lane_upd[15:1]} ^ 16'hB400;
               else             lane_upd = {1'b0, lane_upd[15:1]};
            end
         end
         assign upd[16*gi +: 16]       = lane_upd;
         assign seed_prot[16*gi +: 16] = (seed[16*gi +: 16] == 16'h0000) ?
                                         16'h0001 : seed[16*gi +: 16];
      end
   endgenerate

   always_comb begin
      fsm_d    = fsm_q;
      state_d  = state_q;
      warm_d   = warm_q;
      cnt_d    = cnt_q;
      req_d    = req_q;
      seeded_d = seeded_q;
      if (seed_valid) begin
         // A seed load wins over any simultaneous handshake.
         state_d  = seed_prot;
         warm_d   = WARM_INIT;
         cnt_d    = '0;
         req_d    = 1'b0;
         seeded_d = 1'b1;
         fsm_d    = (WARMUP == 0) ? S_RUN : S_WARMUP;
      end else begin
         case (fsm_q)
            S_WARMUP: begin
               state_d = upd;
               warm_d  = warm_q - 4'd1;
               if (warm_q <= 4'd1) fsm_d = S_RUN;
            end
            S_RUN: begin
               if (r_ready) begin
                  state_d = upd;
                  if (RESEED_INTERVAL != 0 && cnt_q != CNT_MAX) begin
                     cnt_d = cnt_q + CW'(1);
                     if (cnt_q + CW'(1) == CNT_MAX) req_d = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q    <= S_IDLE;
         state_q  <= '0;
         warm_q   <= '0;
         cnt_q    <= '0;
         req_q    <= 1'b0;
         seeded_q <= 1'b0;
      end else begin
         fsm_q    <= fsm_d;
         state_q  <= state_d;
         warm_q   <= warm_d;
         cnt_q    <= cnt_d;
         req_q    <= req_d;
         seeded_q <= seeded_d;
      end
   end

   assign r          = state_q;
   assign r_valid    = (fsm_q == S_RUN);
   assign reseed_req = req_q;
   assign seeded     = seeded_q;

endmodule
